bram_burst_reader: RTL and testbench

//   Streams a burst of consecutive 128-bit words out of the 128x16384 dual-port BRAM

---
 rtl/bram_burst_reader_pkg.sv | 14 +
 rtl/bram_burst_reader_fifo.sv | 49 ++++
 rtl/bram_burst_reader.sv | 104 ++++++++++
 tb/tb_bram_burst_reader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_burst_reader_pkg.sv
// Shared constants and FSM state type for the BRAM burst reader slice.
package bram_burst_reader_pkg;

  localparam int BRAM_DATA_W = 128;
  localparam int BRAM_ADDR_W = 14;
  localparam int BRAM_BUF_D  = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_e;

endpackage

// File: rtl/bram_burst_reader_fifo.sv
// Small synchronous FIFO holding BRAM words plus their last tag; the head is
// read straight from registered storage so the output stream is glitch-free.
module bram_burst_reader_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             din_i,
  output logic [WIDTH-1:0]             dout_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= din_i;
        wrPtr_q        <= nextPtr(wrPtr_q);
      end
      if (pop_i) rdPtr_q <= nextPtr(rdPtr_q);
      if (push_i && !pop_i)      count_q <= count_q + CNT_W'(1);
      else if (pop_i && !push_i) count_q <= count_q - CNT_W'(1);
    end
  end

  assign dout_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bram_burst_reader.sv
// Streams a burst of consecutive BRAM words onto a valid/ready stream,
// hiding the one-cycle read latency behind a credit-controlled FIFO.
module bram_burst_reader
  import bram_burst_reader_pkg::*;
#(
  parameter int DATA_W = BRAM_DATA_W,
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int BUF_D  = BRAM_BUF_D
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] cmd_len_i,
  output logic              bram_en_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [DATA_W-1:0] bram_dout_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(BUF_D+1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic              inflight_q;
  logic              inflightLast_q;

  logic [CNT_W-1:0]  fifoCount;
  logic [DATA_W:0]   fifoHead;
  logic              pop;
  logic              issue;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W:0]    credit;

  assign pop = m_valid_o & m_ready_i;

  // A read may issue only if the word it returns is guaranteed a FIFO slot.
  always_comb begin
    occupancy = {1'b0, fifoCount} + (CNT_W+1)'(inflight_q);
    credit    = (CNT_W+1)'(BUF_D) + (CNT_W+1)'(pop);
    issue     = (state_q == READ) && (occupancy < credit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
    end else begin
      inflight_q     <= issue;
      inflightLast_q <= issue && (remaining_q == '0);
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            addr_q      <= cmd_addr_i;
            remaining_q <= cmd_len_i;
            state_q     <= READ;
          end
        end
        READ: begin
          if (issue) begin
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - ADDR_W'(1);
            if (remaining_q == '0) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last_o) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bram_burst_reader_fifo #(
    .WIDTH (DATA_W+1),
    .DEPTH (BUF_D)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   ({inflightLast_q, bram_dout_i}),
    .dout_o  (fifoHead),
    .count_o (fifoCount)
  );

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign bram_en_o   = issue;
  assign bram_addr_o = addr_q;
  assign m_valid_o   = (fifoCount != '0);
  assign m_last_o    = fifoHead[DATA_W];
  assign m_data_o    = fifoHead[DATA_W-1:0];

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader with a behavioural one-cycle-latency BRAM.
module tb_bram_burst_reader;

  localparam int DW   = 128;
  localparam int AW   = 14;
  localparam int BUFD = 2;

  logic          clk = 1'b0;
  logic          rstN;
  logic          cmdValid;
  logic          cmdReady;
  logic [AW-1:0] cmdAddr;
  logic [AW-1:0] cmdLen;
  logic          bramEn;
  logic [AW-1:0] bramAddr;
  logic [DW-1:0] bramDout = '0;
  logic          mValid;
  logic          mReady;
  logic [DW-1:0] mData;
  logic          mLast;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_burst_reader dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .cmd_valid_i (cmdValid),
    .cmd_ready_o (cmdReady),
    .cmd_addr_i  (cmdAddr),
    .cmd_len_i   (cmdLen),
    .bram_en_o   (bramEn),
    .bram_addr_o (bramAddr),
    .bram_dout_i (bramDout),
    .m_valid_o   (mValid),
    .m_ready_i   (mReady),
    .m_data_o    (mData),
    .m_last_o    (mLast),
    .busy_o      (busy)
  );

  // Preloaded memory image: word i holds {8{i[15:0]}}.
  function automatic logic [DW-1:0] wordOf(input logic [AW-1:0] a);
    return {8{{2'b00, a}}};
  endfunction

  always @(posedge clk) begin
    if (bramEn) bramDout <= wordOf(bramAddr);
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string phase);
    checkOutput({phase, "_cmdReady"}, cmdReady, 1);
    checkOutput({phase, "_bramEn"}, bramEn, 0);
    checkOutput({phase, "_bramAddr"}, bramAddr, 0);
    checkOutput({phase, "_mValid"}, mValid, 0);
    checkOutput({phase, "_mData"}, mData, 0);
    checkOutput({phase, "_mLast"}, mLast, 0);
    checkOutput({phase, "_busy"}, busy, 0);
  endtask

  // Presents a command for one cycle; returns just after the accepting edge.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [AW-1:0] len);
    cmdValid = 1'b1;
    cmdAddr  = addr;
    cmdLen   = len;
    #1;
    checkOutput("cmdReadyIdle", cmdReady, 1);
    @(posedge clk); #1;
    cmdValid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: 20-cycle stall after stallAt beats.
  task automatic runBurst(input logic [AW-1:0] addr, input logic [AW-1:0] len, input int mode,
                          input int stallAt, input int abortAt, input bit junkCmd);
    int k = 0;
    int issued = 0;
    int c = 0;
    int firstValid = -1;
    int lastPop = -1;
    int stallCnt = 0;
    bit prevHold = 0;
    bit done = 0;
    logic [DW-1:0] prevData = '0;
    logic prevLast = 1'b0;
    logic [AW-1:0] ea;
    while (!done && c < 400) begin
      c++;
      if (mode == 0) mReady = 1'b1;
      else if (mode == 1) mReady = 1'($urandom_range(0, 1));
      else if (k == stallAt && stallCnt < 20) begin
        mReady = 1'b0;
        stallCnt++;
      end else mReady = 1'b1;
      if (junkCmd) begin
        cmdValid = 1'b1;
        cmdAddr  = 14'd999;
        cmdLen   = 14'd0;
      end
      #1;
      if (c == 1) begin
        checkOutput("issueLatency", bramEn, 1);
        checkOutput("busyHigh", busy, 1);
        checkOutput("cmdReadyLow", cmdReady, 0);
      end
      if (prevHold) begin
        checkOutput("holdValid", mValid, 1);
        checkOutput("holdData", mData, prevData);
        checkOutput("holdLast", mLast, prevLast);
      end
      if (mode == 2 && !mReady && (issued - k) == BUFD) checkOutput("creditStop", bramEn, 0);
      if (bramEn) begin
        ea = addr + 14'(issued);
        checkOutput("bramAddr", bramAddr, ea);
        issued++;
      end
      if (mode == 2 && !mReady) checkOutput("bufferBound", ((issued - k) <= BUFD), 1);
      if (mValid && firstValid < 0) firstValid = c;
      prevHold = mValid && !mReady;
      prevData = mData;
      prevLast = mLast;
      if (mValid && mReady) begin
        ea = addr + 14'(k);
        checkOutput("beatData", mData, wordOf(ea));
        checkOutput("beatLast", mLast, (k == int'(len)));
        k++;
        lastPop = c;
        if (k == int'(len) + 1) done = 1;
        if (abortAt > 0 && k == abortAt) done = 1;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    if (!done) checkOutput("timeout", 0, 1);
    if (abortAt == 0) begin
      checkOutput("beatCount", k, int'(len) + 1);
      checkOutput("issueCount", issued, int'(len) + 1);
      if (mode == 0) begin
        checkOutput("firstValid", firstValid, 3);
        checkOutput("lastPopCycle", lastPop, 3 + int'(len));
      end
      @(posedge clk); #1;
      cmdValid = 1'b0;
      checkOutput("busyLow", busy, 0);
      checkOutput("cmdReadyBack", cmdReady, 1);
      checkOutput("idleNoValid", mValid, 0);
      @(posedge clk); #1;
      checkOutput("stayIdle", busy, 0);
    end
  endtask

  initial begin
    rstN     = 1'b0;
    cmdValid = 1'b0;
    cmdAddr  = '0;
    cmdLen   = '0;
    mReady   = 1'b0;
    #12;
    checkResetValues("reset");
    rstN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single-word burst");
    applyStimulus(14'd5, 14'd0);
    runBurst(14'd5, 14'd0, 0, 0, 0, 1'b0);

    $display("[TB] eight-word burst at full rate");
    applyStimulus(14'd100, 14'd7);
    runBurst(14'd100, 14'd7, 0, 0, 0, 1'b0);

    $display("[TB] sixteen words with random backpressure");
    applyStimulus(14'd0, 14'd15);
    runBurst(14'd0, 14'd15, 1, 0, 0, 1'b0);

    $display("[TB] burst across the address wrap");
    applyStimulus(14'd16382, 14'd3);
    runBurst(14'd16382, 14'd3, 0, 0, 0, 1'b0);

    $display("[TB] long stall mid-burst");
    applyStimulus(14'd50, 14'd9);
    runBurst(14'd50, 14'd9, 2, 3, 0, 1'b0);

    $display("[TB] reset mid-burst then fresh burst with ignored commands");
    applyStimulus(14'd200, 14'd7);
    runBurst(14'd200, 14'd7, 0, 0, 3, 1'b0);
    rstN = 1'b0;
    #1;
    checkResetValues("midReset");
    #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    applyStimulus(14'd300, 14'd4);
    runBurst(14'd300, 14'd4, 0, 0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
